// File: rtl/math_equation_solver.sv
// Recovers operand a from q = ((1+3c)*(a-b) - 4d) >>> 1 by trying exact signed
// division of 2q+4d+r (r = 0, then 1) by 1+3c, one restoring-division bit per cycle.
module math_equation_solver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [2*WIDTH+3:0] q,
  input  logic signed [WIDTH-1:0]   b,
  input  logic signed [WIDTH-1:0]   c,
  input  logic signed [WIDTH-1:0]   d,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic signed [WIDTH-1:0]   a,
  output logic [1:0]                status
);

  localparam int unsigned QW = 2*WIDTH + 4;
  localparam int unsigned NB = 2*WIDTH + 6;
  localparam int unsigned CW = $clog2(NB);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_AMBIG = 2'b01;
  localparam logic [1:0] ST_NOSOL = 2'b10;
  localparam logic [1:0] ST_OVF   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_DIV0, S_CHK0, S_DIV1, S_CHK1, S_DONE
  } state_t;

  state_t                   r_state;
  logic signed [QW-1:0]     r_q;
  logic signed [WIDTH-1:0]  r_b, r_c, r_d;
  logic signed [NB:0]       r_n0;
  logic signed [NB:0]       r_q0;
  logic                     r_ex0;
  logic                     r_neg;
  logic                     r_msgn;
  logic [NB-1:0]            r_div;
  logic [NB-1:0]            r_quo;
  logic [NB-1:0]            r_rem;
  logic [CW-1:0]            r_cnt;

  logic signed [NB:0] w_q_ext, w_b_ext, w_c_ext, w_d_ext;
  logic signed [NB:0] w_n0, w_n1, w_m;
  logic [NB:0]        w_shift;
  logic               w_ge;
  logic [NB-1:0]      w_rem_nx;
  logic signed [NB:0] w_quo_s, w_qs, w_sel, w_a_wide;
  logic               w_exact, w_inrange;
  logic [NB-WIDTH+1:0] w_hi;

  function automatic logic [NB-1:0] mag(input logic signed [NB:0] v);
    return NB'(v[NB] ? -v : v);
  endfunction

  // Wide signed operands: no intermediate result can overflow NB+1 bits
  assign w_q_ext = {{(NB+1-QW){r_q[QW-1]}}, r_q};
  assign w_b_ext = {{(NB+1-WIDTH){r_b[WIDTH-1]}}, r_b};
  assign w_c_ext = {{(NB+1-WIDTH){r_c[WIDTH-1]}}, r_c};
  assign w_d_ext = {{(NB+1-WIDTH){r_d[WIDTH-1]}}, r_d};
  assign w_n0    = (w_q_ext <<< 1) + (w_d_ext <<< 2);
  assign w_n1    = r_n0 + (NB+1)'(1);
  assign w_m     = w_c_ext + w_c_ext + w_c_ext + (NB+1)'(1);

  // One restoring step: shift next dividend bit into the partial remainder
  assign w_shift  = {r_rem, r_quo[NB-1]};
  assign w_ge     = w_shift >= {1'b0, r_div};
  assign w_rem_nx = NB'(w_shift - (w_ge ? {1'b0, r_div} : '0));

  assign w_quo_s  = $signed({1'b0, r_quo});
  assign w_qs     = r_neg ? -w_quo_s : w_quo_s;
  assign w_exact  = (r_rem == '0);

  assign w_sel     = r_ex0 ? r_q0 : w_qs;
  assign w_a_wide  = w_sel + w_b_ext;
  assign w_hi      = w_a_wide[NB:WIDTH-1];
  assign w_inrange = (&w_hi) | ~(|w_hi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      a       <= '0;
      status  <= ST_OK;
      r_q     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_n0    <= '0;
      r_q0    <= '0;
      r_ex0   <= 1'b0;
      r_neg   <= 1'b0;
      r_msgn  <= 1'b0;
      r_div   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_q     <= q;
            r_b     <= b;
            r_c     <= c;
            r_d     <= d;
            ready_o <= 1'b0;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_n0    <= w_n0;
          r_msgn  <= w_m[NB];
          r_neg   <= w_n0[NB] ^ w_m[NB];
          r_div   <= mag(w_m);
          r_quo   <= mag(w_n0);
          r_rem   <= '0;
          r_cnt   <= CW'(NB - 1);
          r_state <= S_DIV0;
        end
        S_DIV0, S_DIV1: begin
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[NB-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= (r_state == S_DIV0) ? S_CHK0 : S_CHK1;
          end
        end
        S_CHK0: begin
          r_ex0   <= w_exact;
          r_q0    <= w_qs;
          r_neg   <= w_n1[NB] ^ r_msgn;
          r_quo   <= mag(w_n1);
          r_rem   <= '0;
          r_cnt   <= CW'(NB - 1);
          r_state <= S_DIV1;
        end
        S_CHK1: begin
          valid_o <= 1'b1;
          r_state <= S_DONE;
          if (!r_ex0 && !w_exact) begin
            a      <= '0;
            status <= ST_NOSOL;
          end else if (!w_inrange) begin
            a      <= '0;
            status <= ST_OVF;
          end else begin
            a      <= WIDTH'(w_a_wide);
            status <= (r_ex0 && w_exact) ? ST_AMBIG : ST_OK;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/math_equation_solver.md
Name: math_equation_solver

Overview:
- Inverse of the pipelined equation unit q = ((1+3c)*(a-b) - 4d) >>> 1.
- Given q, b, c and d, it recovers operand a by iterative signed division of N = 2q + 4d + r, with r in {0,1}, by M = 1 + 3c.
- Used on the checker/readback path to reconstruct the source operand from a stored result.
- Multi-cycle FSM with a valid/ready handshake on the input and on the output. One transaction in flight at a time.

Parameters:
- WIDTH, 8, width of a, b, c, d. q is 2*WIDTH+4 bits.
- NB (localparam), 2*WIDTH+6, width of the dividend magnitude and number of division iterations per attempt.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- valid_i  in  1  input request valid.
- ready_o  out  1  block can accept a request.
- q  in  2*WIDTH+4 signed  forward result.
- b  in  WIDTH signed  operand b.
- c  in  WIDTH signed  operand c.
- d  in  WIDTH signed  operand d.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- a  out  WIDTH signed  recovered operand.
- status  out  2  result status: 00 ok, 01 ambiguous, 10 no_solution, 11 overflow.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; any transaction in progress is aborted and discarded.
  - Output values: ready_o=1, valid_o=0, a=0, status=00.
- Input handshake and capture:
  - Accept on the rising edge where valid_i && ready_o.
  - q, b, c, d are captured only at acceptance. Later changes on these inputs are ignored.
  - ready_o is high only in IDLE.
- Arithmetic:
  - Performed at NB+1 bits signed; no intermediate overflow.
  - M = 1 + 3*c is never 0.
  - N0 = 2*q + 4*d and N1 = N0 + 1.
- Division:
  - Restoring division on |N| / |M|, one quotient bit per cycle, NB cycles per attempt.
  - Quotient sign = sign(N) xor sign(M). The attempt is exact iff the remainder is 0.
- FSM states and transitions:
  - IDLE -> PREP on acceptance.
  - PREP (1 cycle): form N0 and M magnitudes.
  - DIV0 (NB cycles) -> CHK0 (1 cycle): record exact0 and quotient Q0; load N1.
  - DIV1 (NB cycles) -> CHK1 (1 cycle): record exact1 and quotient Q1.
  - CHK1 -> DONE.
  - DONE: valid_o=1. Stay in DONE while !ready_i; DONE -> IDLE on ready_i.
  - Both attempts always run.
- Latency: valid_o rises exactly 2*NB+3 edges after the acceptance edge (47 for WIDTH=8).
- Result selection:
  - Use Q0 if exact0, else Q1 if exact1.
  - a = Q + b, computed wide, then range-checked against signed WIDTH.
- Status, in priority order:
  - neither attempt exact -> no_solution, a=0.
  - else result out of range -> overflow, a=0.
  - else both attempts exact -> ambiguous, a from Q0.
  - else ok.
- Output hold: a and status are held stable while valid_o && !ready_i. valid_o deasserts on the edge after ready_i is sampled high in DONE.
- Back-to-back: ready_o returns to 1 the cycle after output acceptance. There is no input/output overlap.
- Reset mid-DIV or mid-DONE: outputs return to their reset values immediately; no partial result is ever presented.

Test Plan:
- WIDTH=8; q=14, b=3, c=2, d=5 -> N0=48 not exact, N1=49/7=7 -> a=10, status=00, valid_o exactly 47 cycles after acceptance.
- q=-1, b=2, c=0, d=1 -> M=1, both attempts exact -> a=4 (from Q0=2), status=01.
- q=-48449, b=127, c=127, d=-128 -> N0=-97410, M=382, Q0=-255 -> a=-128, status=00 (extreme operands, negative quotient).
- q=1, b=0, c=1, d=0 -> 2 and 3 not divisible by 4 -> a=0, status=10. Separately, q=2, b=127, c=1, d=0 -> Q0=1, a=128 out of range -> a=0, status=11.
- Backpressure:
  - Hold ready_i=0 for 10 cycles in DONE -> valid_o, a and status are stable; ready_o=0 throughout.
  - valid_i pulses during busy are not accepted.
  - ready_i=1 -> ready_o=1 the next cycle.
- Drive rst low during DIV1 -> valid_o=0 and ready_o=1 immediately. A new request after reset completes with the correct result and the full 47-cycle latency.
